level_meter: RTL and testbench

LEVEL_METER -- requirements
Module: level_meter

---
 rtl/level_meter_pkg.sv | 23 ++
 rtl/level_meter_if.sv | 22 ++
 rtl/level_meter_col_update.sv | 33 +++
 rtl/level_meter.sv | 94 +++++++++
 tb/tb_level_meter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/level_meter_pkg.sv
// level_meter_pkg: shared sizes, FSM state type and per-column state record
// for the spectrum level meter.
package level_meter_pkg;
  localparam int NUM_COLS = 16;
  localparam int LVL_W    = 5;
  localparam int SAMPLE_W = 10;
  localparam int HOLD_W   = 8;
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Everything the column updater needs to know about one column.
  typedef struct packed {
    logic [LVL_W-1:0]  bar;
    logic [LVL_W-1:0]  peak;
    logic [HOLD_W-1:0] hold;
  } col_state_t;

  // A magnitude maps to a display level by keeping its top LVL_W bits.
  function automatic logic [LVL_W-1:0] to_level(input logic [SAMPLE_W-1:0] t);
    return t[SAMPLE_W-1 -: LVL_W];
  endfunction
endpackage

// File: rtl/level_meter_if.sv
// level_meter_if: frame input, display read port and status bundle.
//   new_t      : one-cycle "t holds a new frame" strobe
//   t          : band magnitudes, t[c] is column c
//   rd_col     : column to read
//   rd_bar/peak: registered read data
//   busy, frame_done, overrun : status
// master = producer/display side, slave = level_meter.
interface level_meter_if import level_meter_pkg::*;;
  logic                               new_t;
  logic [NUM_COLS-1:0][SAMPLE_W-1:0]  t;
  logic [COL_W-1:0]                   rd_col;
  logic [LVL_W-1:0]                   rd_bar;
  logic [LVL_W-1:0]                   rd_peak;
  logic                               busy;
  logic                               frame_done;
  logic                               overrun;

  modport master (output new_t, t, rd_col,
                  input  rd_bar, rd_peak, busy, frame_done, overrun);
  modport slave  (input  new_t, t, rd_col,
                  output rd_bar, rd_peak, busy, frame_done, overrun);
endinterface

// File: rtl/level_meter_col_update.sv
// level_meter_col_update: combinational next state of one column.
//   level_i : new level of the column (0..31)
//   cur_i   : stored bar/peak/hold
//   nxt_o   : updated bar/peak/hold
// Bar: instant attack, 1-per-frame decay. Peak: latches on a new high,
// holds for HOLD_FRAMES frames, then decays but never below the bar.
module level_meter_col_update import level_meter_pkg::*; #(
  parameter int HOLD_FRAMES = 8
) (
  input  logic [LVL_W-1:0] level_i,
  input  col_state_t       cur_i,
  output col_state_t       nxt_o
);
  logic [LVL_W-1:0] bar_n;
  logic [LVL_W-1:0] peak_dec;

  always_comb begin
    // bar > level >= 0 on the decay path, so bar - 1 cannot underflow
    bar_n    = (level_i >= cur_i.bar) ? level_i : cur_i.bar - LVL_W'(1);
    // peak > level >= 0 on the decay path as well
    peak_dec = cur_i.peak - LVL_W'(1);
    nxt_o      = cur_i;
    nxt_o.bar  = bar_n;
    if (level_i >= cur_i.peak) begin
      nxt_o.peak = level_i;
      nxt_o.hold = HOLD_W'(HOLD_FRAMES);
    end else if (cur_i.hold != '0) begin
      nxt_o.hold = cur_i.hold - HOLD_W'(1);
    end else begin
      nxt_o.peak = (peak_dec > bar_n) ? peak_dec : bar_n;
    end
  end
endmodule

// File: rtl/level_meter.sv
// level_meter: 16-column bar/peak meter. A new_t strobe in IDLE snapshots
// t, then SCAN walks one column per clock through a single shared
// column updater, then DONE for one cycle.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : level_meter_if.slave (frame in, read port, status out)
module level_meter import level_meter_pkg::*; #(
  parameter int HOLD_FRAMES = 8
) (
  input logic          clk,
  input logic          reset,
  level_meter_if.slave bus
);
  state_e                             state_q;
  logic [COL_W-1:0]                   col_q;
  logic [NUM_COLS-1:0][SAMPLE_W-1:0]  snap_q;
  logic [NUM_COLS-1:0][LVL_W-1:0]     bar_q;
  logic [NUM_COLS-1:0][LVL_W-1:0]     peak_q;
  logic [NUM_COLS-1:0][HOLD_W-1:0]    hold_q;
  logic [LVL_W-1:0]                   rd_bar_q, rd_peak_q;
  logic                               busy_q, done_q, overrun_q;

  col_state_t       cur_d, nxt_d;
  logic [LVL_W-1:0] level_d;

  assign level_d = to_level(snap_q[col_q]);
  assign cur_d   = '{bar: bar_q[col_q], peak: peak_q[col_q], hold: hold_q[col_q]};

  level_meter_col_update #(.HOLD_FRAMES(HOLD_FRAMES)) u_col (
    .level_i (level_d),
    .cur_i   (cur_d),
    .nxt_o   (nxt_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      snap_q    <= '0;
      bar_q     <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      rd_bar_q  <= '0;
      rd_peak_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Read samples the arrays before this edge's write: same-column
      // read/write returns the old value.
      rd_bar_q  <= bar_q[bus.rd_col];
      rd_peak_q <= peak_q[bus.rd_col];
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.new_t) begin
            snap_q  <= bus.t;
            col_q   <= '0;
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          overrun_q     <= bus.new_t;
          bar_q[col_q]  <= nxt_d.bar;
          peak_q[col_q] <= nxt_d.peak;
          hold_q[col_q] <= nxt_d.hold;
          col_q         <= col_q + COL_W'(1);
          if (col_q == COL_W'(NUM_COLS - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          overrun_q <= bus.new_t;
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_bar     = rd_bar_q;
  assign bus.rd_peak    = rd_peak_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: table-driven level checks, a bar/peak reference model,
// read scoreboard, plus decay, overrun and mid-scan reset sequences.
module tb_level_meter;
  import level_meter_pkg::*;
  localparam int HF = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  level_meter_if bus();
  level_meter #(.HOLD_FRAMES(HF)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct { int t; int lvl; } vec_t;
  typedef struct { int col; int bar; int peak; } rd_exp_t;
  vec_t    tbl [16];
  rd_exp_t sbq [$];
  int tv [16];
  int mbar [16], mpeak [16], mhold [16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < 16; c++) begin mbar[c] = 0; mpeak[c] = 0; mhold[c] = 0; end
  endfunction

  function automatic void model_frame();
    for (int c = 0; c < 16; c++) begin
      int lvl;
      lvl = tv[c] / 32;
      if (lvl >= mbar[c]) mbar[c] = lvl;
      else if (mbar[c] > 0) mbar[c] = mbar[c] - 1;
      if (lvl >= mpeak[c]) begin mpeak[c] = lvl; mhold[c] = HF; end
      else if (mhold[c] > 0) mhold[c] = mhold[c] - 1;
      else mpeak[c] = (mpeak[c] - 1 > mbar[c]) ? mpeak[c] - 1 : mbar[c];
    end
  endfunction

  // Drive a read, queue its expectation, compare when the data appears.
  task automatic read_check(input string tag, input int c, input int eb, input int ep);
    rd_exp_t e;
    @(negedge clk);
    bus.rd_col = COL_W'(c);
    sbq.push_back('{c, eb, ep});
    @(posedge clk); #1;
    e = sbq.pop_front();
    check($sformatf("%s col%0d bar", tag, e.col), int'(bus.rd_bar), e.bar);
    check($sformatf("%s col%0d peak", tag, e.col), int'(bus.rd_peak), e.peak);
    check($sformatf("%s col%0d peak>=bar", tag, e.col),
          int'(bus.rd_peak >= bus.rd_bar), 1);
  endtask

  task automatic sweep(input string tag);
    for (int c = 0; c < 16; c++) read_check(tag, c, mbar[c], mpeak[c]);
  endtask

  // Run one frame from tv[]; optionally inject a dropped strobe at
  // busy cycle `inject`, and check read-during-write on column rdc.
  task automatic run_frame(input string tag, input int inject, input int rdc, input int exp_ovr);
    int cnt, fd, ov;
    @(negedge clk);
    for (int c = 0; c < 16; c++) bus.t[c] = SAMPLE_W'(tv[c]);
    bus.rd_col = COL_W'(rdc);
    bus.new_t  = 1'b1;
    @(negedge clk);
    bus.new_t = 1'b0;
    cnt = 0; fd = 0; ov = 0;
    while (bus.busy && cnt < 100) begin
      if (bus.frame_done) fd++;
      if (bus.overrun) ov++;
      if (cnt == rdc + 1)
        check($sformatf("%s rd-during-write old bar", tag), int'(bus.rd_bar), mbar[rdc]);
      if (cnt == inject) begin
        bus.new_t = 1'b1;
        bus.t[0]  = SAMPLE_W'(1023);
      end else if (cnt == inject + 1) begin
        bus.new_t = 1'b0;
        bus.t[0]  = SAMPLE_W'(tv[0]);
      end
      cnt++;
      @(negedge clk);
    end
    if (bus.overrun) ov++;
    check($sformatf("%s busy cycles", tag), cnt, 17);
    check($sformatf("%s frame_done pulses", tag), fd, 1);
    check($sformatf("%s overrun pulses", tag), ov, exp_ovr);
    model_frame();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, int'(bus.busy), 0);
    check({tag, " frame_done"}, int'(bus.frame_done), 0);
    check({tag, " overrun"}, int'(bus.overrun), 0);
    check({tag, " rd_bar"}, int'(bus.rd_bar), 0);
    check({tag, " rd_peak"}, int'(bus.rd_peak), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{640, 20};  tbl[1]  = '{31, 0};    tbl[2]  = '{32, 1};
    tbl[3]  = '{63, 1};    tbl[4]  = '{64, 2};    tbl[5]  = '{0, 0};
    tbl[6]  = '{1023, 31}; tbl[7]  = '{992, 31};  tbl[8]  = '{991, 30};
    tbl[9]  = '{511, 15};  tbl[10] = '{512, 16};  tbl[11] = '{100, 3};
    tbl[12] = '{300, 9};   tbl[13] = '{700, 21};  tbl[14] = '{960, 30};
    tbl[15] = '{33, 1};

    bus.new_t = 1'b0; bus.t = '0; bus.rd_col = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_idle_outputs("in reset");
    reset = 1'b1;

    // Reset state
    sweep("reset");
    check("reset busy", int'(bus.busy), 0);

    // Single band, then 30 decay frames
    for (int c = 0; c < 16; c++) tv[c] = 0;
    tv[3] = 640;
    run_frame("t3=640", -5, 3, 0);
    sweep("t3=640");
    tv[3] = 0;
    for (int k = 1; k <= 30; k++) begin
      int eb, ep;
      run_frame($sformatf("decay%0d", k), -5, 3, 0);
      eb = (20 - k > 0) ? 20 - k : 0;
      ep = (k <= HF) ? 20 : ((20 - (k - HF) > 0) ? 20 - (k - HF) : 0);
      read_check($sformatf("decay%0d", k), 3, eb, ep);
      read_check($sformatf("decay%0d model", k), 3, mbar[3], mpeak[3]);
    end

    // Level table from a clean state
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_clear();
    for (int c = 0; c < 16; c++) tv[c] = tbl[c].t;
    run_frame("table", -5, 3, 0);
    for (int c = 0; c < 16; c++) read_check("table", c, tbl[c].lvl, tbl[c].lvl);

    // Dropped strobe mid-scan: snapshot must stay all-zero
    for (int c = 0; c < 16; c++) tv[c] = 0;
    run_frame("overrun", 5, 3, 1);
    read_check("overrun", 0, 19, 20);
    sweep("overrun");

    // Reset at SCAN column 7
    tv[5] = 800;
    @(negedge clk);
    for (int c = 0; c < 16; c++) bus.t[c] = SAMPLE_W'(tv[c]);
    bus.rd_col = COL_W'(6);
    bus.new_t = 1'b1;
    @(negedge clk);
    bus.new_t = 1'b0;
    repeat (7) @(negedge clk);
    check("pre-reset busy", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid-scan reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check("post-reset idle busy", int'(bus.busy), 0);
    sweep("post-reset");

    for (int c = 0; c < 16; c++) tv[c] = 0;
    tv[15] = 1023;
    run_frame("t15=1023", -5, 3, 0);
    read_check("t15=1023", 15, 31, 31);
    tv[15] = 31;
    run_frame("t15=31", -5, 15, 0);
    read_check("t15=31", 15, 30, 31);
    sweep("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
